cim_tile_arbiter: RTL
=====================

Name: cim_tile_arbiter

Overview:
- Shares one CIM crossbar tile between NUM_REQ layer controllers (conv, flatten/FC and similar), each issuing the usual we/addr/start handshake against CIM ready.
- Round-robin grant, locked for a requester's full multi-pass (bit-serial) operation.
- Sits between the layer controllers and the tile's write/start/ready interface.

Parameters:
- NUM_REQ, 4, number of requesting controllers (>=2).
- ADDR_WIDTH, 4, CIM/ibuf address width per requester.
- IDX_WIDTH, (NUM_REQ<=2)?1:$clog2(NUM_REQ), owner index width.
- CNT_WIDTH, 16, pass counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_req  in  NUM_REQ  per-requester ownership request (level)
- i_we  in  NUM_REQ  per-requester CIM write enable
- i_start  in  NUM_REQ  per-requester CIM start
- i_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- o_gnt  out  NUM_REQ  one-hot grant, registered
- o_ready  out  NUM_REQ  per-requester CIM ready view
- i_cim_ready  in  1  tile idle/finished
- o_cim_we  out  1  muxed write enable to tile
- o_cim_start  out  1  muxed start to tile
- o_cim_addr  out  ADDR_WIDTH  muxed address to tile
- o_owner  out  IDX_WIDTH  current/last owner index
- o_busy  out  1  high when not in idle
- o_pass_count  out  CNT_WIDTH  CIM runs completed by current owner, saturating

Behaviour:
- Reset values:
  - state = s_arb_idle; o_gnt = 0; o_owner = 0; rr_ptr = 0; o_pass_count = 0.
  - o_cim_we = 0, o_cim_start = 0, o_cim_addr = 0, o_ready = 0, o_busy = 0.
- Reset mid-operation aborts everything and drops the grant in the next cycle. The tile is not notified.
- o_ready[k] = o_gnt[k] & i_cim_ready (combinational). Non-owners always see 0.
- Mux:
  - In s_arb_grant: o_cim_we/o_cim_start/o_cim_addr = owner's inputs (combinational).
  - In all other states: we = start = addr = 0.
  - Non-owner we/start are ignored entirely.
- States:
  - s_arb_idle:
    - If any i_req and i_cim_ready: select the first requesting index at or after rr_ptr (cyclic scan), load o_owner, set o_gnt one-hot, clear pass count, go s_arb_grant.
    - Else stay. No grant while i_cim_ready = 0.
    - Grant visible the cycle after the request is sampled (1-cycle latency).
  - s_arb_grant: owner consumes/writes freely.
    - If i_cim_ready falls: go s_arb_run. This is the tile accepting the start; the start may be held high, as the owner does.
    - Else if owner's i_req = 0 and i_start = 0: go s_arb_release.
    - Else stay.
  - s_arb_run:
    - Mux outputs forced 0; grant held.
    - On i_cim_ready rising: o_pass_count += 1 (saturate at all-ones), go s_arb_grant. The owner keeps the tile for the next bit pass.
    - i_req drop here has no effect until completion.
  - s_arb_release:
    - One cycle: o_gnt = 0, rr_ptr = (o_owner+1) mod NUM_REQ, go s_arb_idle.
    - This guarantees at least one dead cycle between owners and no glitch on tile inputs.
    - o_owner keeps the last value.
- Simultaneous requests resolved purely by rr_ptr. Wrap from NUM_REQ-1 to 0.
- A requester that re-asserts i_req immediately after release is served again only if no other index between rr_ptr and itself requests.
- o_gnt is always one-hot or zero. Assert this in the bench.
- o_busy = (state != s_arb_idle).

Test Plan:
- Single requester 0 held for 8 passes, tile model drops ready 1 cycle after start and returns it 5 cycles later -> o_gnt = 0001 one cycle after i_req; o_pass_count = 8; release cycle, then o_gnt = 0 and rr_ptr = 1.
- Requesters 0, 1 and 2 assert together from reset -> grants 0, 1, 2 in order, each separated by exactly one cycle with o_gnt = 0; o_owner = 0, 1, 2.
- Requester 3 owns the tile and releases while 0 and 3 are requesting -> next grant goes to 0 (wrap-around), not 3.
- Non-owner 1 drives i_we = 1, i_start = 1, i_addr = 5 while 2 owns in s_arb_grant -> tile sees requester 2's values only; o_ready[1] = 0 throughout.
- Owner drops i_req in s_arb_run -> grant held until i_cim_ready rises, then s_arb_grant, release, idle; o_pass_count incremented once.
- rst asserted in s_arb_run with i_cim_ready = 0 -> next cycle o_gnt = 0, o_busy = 0, o_pass_count = 0; with i_req = 0010 and i_cim_ready = 1 after reset, o_gnt = 0010 exactly one cycle later.

Source files
------------

// File: rtl/cim_tile_arbiter.sv
// cim_tile_arbiter: shares one CIM crossbar tile between NUM_REQ layer
// controllers. Round-robin grant, held for the owner's full multi-pass job.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_req             per-requester ownership request (level)
//   i_we, i_start     per-requester CIM write enable / start
//   i_addr            packed per-requester addresses, k at [k*AW +: AW]
//   o_gnt             registered one-hot grant
//   o_ready           per-requester view of tile ready (owner only)
//   i_cim_ready       tile idle/finished
//   o_cim_we          muxed write enable to the tile
//   o_cim_start       muxed start to the tile
//   o_cim_addr        muxed address to the tile
//   o_owner           current/last owner index
//   o_busy            arbiter not idle
//   o_pass_count      tile runs completed by the current owner (saturating)

module cim_tile_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 4,
   parameter int IDX_WIDTH  = (NUM_REQ <= 2) ? 1 : $clog2(NUM_REQ),
   parameter int CNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            i_req,
   input  logic [NUM_REQ-1:0]            i_we,
   input  logic [NUM_REQ-1:0]            i_start,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
   output logic [NUM_REQ-1:0]            o_gnt,
   output logic [NUM_REQ-1:0]            o_ready,
   input  logic                          i_cim_ready,
   output logic                          o_cim_we,
   output logic                          o_cim_start,
   output logic [ADDR_WIDTH-1:0]         o_cim_addr,
   output logic [IDX_WIDTH-1:0]          o_owner,
   output logic                          o_busy,
   output logic [CNT_WIDTH-1:0]          o_pass_count
);

   typedef enum logic [1:0] {
      s_arb_idle,
      s_arb_grant,
      s_arb_run,
      s_arb_release
   } state_t;

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REQ - 1);
   localparam logic [IDX_WIDTH-1:0] IDX_ONE  = IDX_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   state_t                 state_q, state_d;
   logic [NUM_REQ-1:0]     gnt_q, gnt_d;
   logic [IDX_WIDTH-1:0]   owner_q, owner_d;
   logic [IDX_WIDTH-1:0]   rr_q, rr_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

   logic [ADDR_WIDTH-1:0]  addr_a [NUM_REQ];
   logic [IDX_WIDTH-1:0]   pick;
   logic [IDX_WIDTH-1:0]   scan;
   logic                   found;
   logic [IDX_WIDTH-1:0]   owner_nxt;
   logic                   own_req;
   logic                   own_we;
   logic                   own_start;
   logic [ADDR_WIDTH-1:0]  own_addr;
   logic                   mux_en;

   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         addr_a[k] = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end

   // Cyclic scan starting at rr_q; first requester found wins.
   always_comb begin
      found = 1'b0;
      pick  = rr_q;
      scan  = rr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && i_req[scan]) begin
            found = 1'b1;
            pick  = scan;
         end
         scan = (scan == LAST_IDX) ? '0 : scan + IDX_ONE;
      end
   end

   assign owner_nxt = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_ONE;

   assign own_req   = i_req[owner_q];
   assign own_we    = i_we[owner_q];
   assign own_start = i_start[owner_q];
   assign own_addr  = addr_a[owner_q];

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         s_arb_idle: begin
            if (found && i_cim_ready) begin
               owner_d     = pick;
               gnt_d       = '0;
               gnt_d[pick] = 1'b1;
               cnt_d       = '0;
               state_d     = s_arb_grant;
            end
         end
         s_arb_grant: begin
            // Ready dropping means the tile took the start.
            if (!i_cim_ready) begin
               state_d = s_arb_run;
            end else if (!own_req && !own_start) begin
               state_d = s_arb_release;
            end
         end
         s_arb_run: begin
            // Entered with ready low, so ready high here is its rise.
            if (i_cim_ready) begin
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + CNT_ONE;
               end
               state_d = s_arb_grant;
            end
         end
         s_arb_release: begin
            // Dead cycle between owners; owner index is kept.
            gnt_d   = '0;
            rr_d    = owner_nxt;
            state_d = s_arb_idle;
         end
         default: begin
            state_d = s_arb_idle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= s_arb_idle;
         gnt_q   <= '0;
         owner_q <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mux_en = (state_q == s_arb_grant);

   assign o_cim_we     = mux_en & own_we;
   assign o_cim_start  = mux_en & own_start;
   assign o_cim_addr   = mux_en ? own_addr : '0;
   assign o_gnt        = gnt_q;
   assign o_ready      = gnt_q & {NUM_REQ{i_cim_ready}};
   assign o_owner      = owner_q;
   assign o_busy       = (state_q != s_arb_idle);
   assign o_pass_count = cnt_q;

endmodule
